// File: rtl/pipe_reg_chain.sv
// Stallable, flushable WIDTH x STAGES pipeline register chain with valid/ready handshake.
// Define PIPE_REG_CHAIN_DATA_CLEAR_EN to reload RESET_VALUE into every stage that goes empty.
module pipe_reg_chain #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WIDTH-1:0]                 in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [$clog2(STAGES+1)-1:0]      count
);

  localparam int unsigned CW = $clog2(STAGES + 1);

`ifdef PIPE_REG_CHAIN_DATA_CLEAR_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic [STAGES-1:0] rdy;
  logic              acceptIn;
  logic              outXfer;

  // A stage can take a word if it is empty or its own word moves on; this
  // ripples from the consumer back, giving the out_ready -> in_ready path.
  always_comb begin
    logic chainRdy;
    chainRdy = !valid_q[STAGES-1] || out_ready;
    rdy = '0;
    rdy[STAGES-1] = chainRdy;
    for (int i = int'(STAGES) - 2; i >= 0; i--) begin
      chainRdy = !valid_q[i] || chainRdy;
      rdy[i] = chainRdy;
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = valid_q[STAGES-1] && !flush;
  assign out_data  = data_q[STAGES-1];
  assign count     = count_q;
  assign acceptIn  = in_valid && in_ready;
  assign outXfer   = out_valid && out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q + CW'(acceptIn) - CW'(outXfer);
    if (flush) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      if (acceptIn) begin
        valid_d[0] = 1'b1;
        data_d[0]  = in_data;
      end else if (rdy[0]) begin
        valid_d[0] = 1'b0;
      end
      // A ready stage takes whatever its upstream neighbour holds, bubble or word.
      for (int i = 1; i < int'(STAGES); i++) begin
        if (rdy[i]) begin
          valid_d[i] = valid_q[i-1];
          if (valid_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
    end
    if (ClearEn) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        if (!valid_d[i]) begin
          data_d[i] = RESET_VALUE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= RESET_VALUE;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomised self-checking bench for pipe_reg_chain against a conveyor-style
// reference model: each word carries its stage position and advances unless blocked.
module tb_pipe_reg_chain;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned STAGES = 3;
  localparam logic [7:0] RESET_VALUE = 8'hA5;

`ifdef PIPE_REG_CHAIN_DATA_CLEAR_EN
  localparam bit ClearEn = 1'b1;
`else
  localparam bit ClearEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       flush;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData;
  logic [1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    int         pos;
  } word_t;

  word_t      chain[$];
  logic [7:0] lastData;

  pipe_reg_chain #(
    .WIDTH(WIDTH),
    .STAGES(STAGES),
    .RESET_VALUE(RESET_VALUE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(inValid),
    .in_ready(inReady),
    .in_data(inData),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_data(outData),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs, checks the DUT against the model, then advances the model.
  task automatic applyStimulus(input bit r, input bit f, input bit iv, input logic [7:0] d, input bit ordy);
    bit         expReady;
    bit         expValid;
    logic [7:0] expData;
    word_t      nextChain[$];
    int         prevPos;
    int         np;

    @(negedge clk);
    rst = r;
    flush = f;
    inValid = iv;
    inData = d;
    outReady = ordy;
    #1;

    expReady = ((chain.size() < int'(STAGES)) || ordy) && !f;
    expValid = (chain.size() > 0) && (chain[0].pos == int'(STAGES) - 1) && !f;
    if ((chain.size() > 0) && (chain[0].pos == int'(STAGES) - 1)) begin
      expData = chain[0].d;
    end else begin
      expData = ClearEn ? RESET_VALUE : lastData;
    end
    checkOutput("in_ready", 32'(inReady), 32'(expReady));
    checkOutput("out_valid", 32'(outValid), 32'(expValid));
    checkOutput("out_data", 32'(outData), 32'(expData));
    checkOutput("count", 32'(count), 32'(chain.size()));

    if (r) begin
      chain.delete();
      lastData = RESET_VALUE;
    end else if (f) begin
      chain.delete();
    end else begin
      prevPos = int'(STAGES);
      foreach (chain[k]) begin
        if (chain[k].pos == int'(STAGES) - 1) begin
          if (ordy) continue;
          np = chain[k].pos;
        end else begin
          np = (chain[k].pos + 1 < prevPos) ? chain[k].pos + 1 : chain[k].pos;
        end
        if ((np == int'(STAGES) - 1) && (chain[k].pos != np)) lastData = chain[k].d;
        nextChain.push_back('{d: chain[k].d, pos: np});
        prevPos = np;
      end
      if (iv && expReady) begin
        if (prevPos == 0) begin
          errors++;
          $display("[TB] FAIL model_stage0: got occupied expected free at %0t", $time);
        end
        nextChain.push_back('{d: d, pos: 0});
        if (STAGES == 1) lastData = d;
      end
      chain = nextChain;
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    inValid = 1'b0;
    inData = '0;
    outReady = 1'b0;
    repeat (2) @(posedge clk);
    chain.delete();
    lastData = RESET_VALUE;

    // reset state is checked on the first cycle after reset drops
    applyStimulus(0, 0, 0, 8'h00, 0);

    // streaming
    applyStimulus(0, 0, 1, 8'h01, 1);
    applyStimulus(0, 0, 1, 8'h02, 1);
    applyStimulus(0, 0, 1, 8'h03, 1);
    repeat (4) applyStimulus(0, 0, 0, 8'h00, 1);

    // back-pressure, then simultaneous transfer and accept when full
    applyStimulus(0, 0, 1, 8'h10, 0);
    applyStimulus(0, 0, 1, 8'h11, 0);
    applyStimulus(0, 0, 1, 8'h12, 0);
    applyStimulus(0, 0, 1, 8'h13, 0);
    applyStimulus(0, 0, 1, 8'h13, 1);
    repeat (4) applyStimulus(0, 0, 0, 8'h00, 1);

    // bubble collapse
    applyStimulus(0, 0, 1, 8'h20, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    applyStimulus(0, 0, 1, 8'h21, 0);
    applyStimulus(0, 0, 0, 8'h00, 0);
    repeat (3) applyStimulus(0, 0, 0, 8'h00, 1);

    // flush with a full chain and a competing input
    applyStimulus(0, 0, 1, 8'h30, 0);
    applyStimulus(0, 0, 1, 8'h31, 0);
    applyStimulus(0, 0, 1, 8'h32, 0);
    applyStimulus(0, 0, 1, 8'h33, 1);
    applyStimulus(0, 1, 1, 8'h34, 1);
    repeat (2) applyStimulus(0, 0, 0, 8'h00, 1);

    // reset mid-stream
    applyStimulus(0, 0, 1, 8'h40, 0);
    applyStimulus(0, 0, 1, 8'h41, 0);
    applyStimulus(1, 0, 0, 8'h00, 1);
    repeat (3) applyStimulus(0, 0, 0, 8'h00, 1);

    // random traffic with occasional flush and reset
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 4),
                    ($urandom_range(0, 99) < 65),
                    8'($urandom_range(0, 255)),
                    ($urandom_range(0, 99) < 55));
    end
    applyStimulus(0, 0, 0, 8'h00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
